rnn_step_ctrl: RTL and testbench

RNN_STEP_CTRL -- requirements
Module: rnn_step_ctrl

---
 rtl/rnn_step_ctrl.sv | 153 +++++++++++++++
 tb/tb_rnn_step_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rnn_step_ctrl.sv
// One RNN time step: h' = ReLU(sat16((W0^T x + W1^T h + (b<<8)) >>> 8)) over a
// 4-input / 16-hidden Q8.8 tensor set, one MAC term per cycle.
module rnn_step_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] x_in,
    output logic        busy,
    output logic        done,
    output logic [1:0]  w0_seli,
    output logic [3:0]  w0_selj,
    input  logic [15:0] w0_data,
    output logic [3:0]  w1_seli,
    output logic [3:0]  w1_selj,
    input  logic [15:0] w1_data,
    output logic [3:0]  b_sel,
    input  logic [15:0] b_data,
    output logic [3:0]  h_sel,
    input  logic [15:0] h_rdata,
    output logic        h_write,
    output logic [15:0] h_wdata,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAC  = 3'd1,
        S_ACT  = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             state;
    logic [3:0]         j;
    logic [4:0]         t;
    logic [3:0]         n;
    logic signed [39:0] acc;
    logic signed [15:0] x_lat [4];
    logic [15:0]        res_buf [16];

    logic [4:0]         prev_t;
    logic signed [31:0] prod;
    logic signed [39:0] sum_full;
    logic signed [39:0] shifted;
    logic [15:0]        act_val;

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // Read data always belongs to the term issued one cycle earlier.
    assign prev_t = t - 5'd1;

    always_comb begin
        if (prev_t < 5'd4) prod = x_lat[prev_t[1:0]] * $signed(w0_data);
        else               prod = $signed(h_rdata) * $signed(w1_data);
    end

    always_comb begin
        sum_full = acc + $signed({{16{b_data[15]}}, b_data, 8'h00});
        shifted  = sum_full >>> 8;
        if (shifted > 40'sd32767)       act_val = 16'h7fff;
        else if (shifted < -40'sd32768) act_val = 16'h8000;
        else                            act_val = shifted[15:0];
        if (act_val[15]) act_val = 16'h0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            j       <= '0;
            t       <= '0;
            n       <= '0;
            acc     <= '0;
            done    <= 1'b0;
            h_write <= 1'b0;
            h_wdata <= '0;
            w0_seli <= '0;
            w0_selj <= '0;
            w1_seli <= '0;
            w1_selj <= '0;
            b_sel   <= '0;
            h_sel   <= '0;
            for (int i = 0; i < 4; i++)  x_lat[i]   <= '0;
            for (int i = 0; i < 16; i++) res_buf[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 4; i++) x_lat[i] <= x_in[16*i +: 16];
                        j       <= '0;
                        t       <= '0;
                        acc     <= '0;
                        w0_seli <= '0;
                        w0_selj <= '0;
                        state   <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (t != 5'd0) acc <= acc + {{8{prod[31]}}, prod};
                    if (t == 5'd20) begin
                        state <= S_ACT;
                    end else begin
                        t <= t + 5'd1;
                        // Selects are set up for term t+1.
                        if (t < 5'd3) begin
                            w0_seli <= 2'(t + 5'd1);
                        end else if (t < 5'd19) begin
                            h_sel   <= 4'(t - 5'd3);
                            w1_seli <= 4'(t - 5'd3);
                            w1_selj <= j;
                        end else begin
                            b_sel <= j;
                        end
                    end
                end
                S_ACT: begin
                    res_buf[j] <= act_val;
                    if (j == 4'd15) begin
                        n       <= '0;
                        h_write <= 1'b1;
                        h_sel   <= '0;
                        h_wdata <= res_buf[0];
                        state   <= S_WB;
                    end else begin
                        j       <= j + 4'd1;
                        t       <= '0;
                        acc     <= '0;
                        w0_seli <= '0;
                        w0_selj <= j + 4'd1;
                        state   <= S_MAC;
                    end
                end
                S_WB: begin
                    if (n == 4'd15) begin
                        h_write <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        n       <= n + 4'd1;
                        h_sel   <= n + 4'd1;
                        h_wdata <= res_buf[n + 4'd1];
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rnn_step_ctrl.sv
// Bench for rnn_step_ctrl: tensor memories with 1-cycle reads, an arithmetic
// reference model feeding an expected queue, and directed plus random steps.
module tb_rnn_step_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] x_in = '0;
    logic        busy, done, h_write;
    logic [1:0]  w0_seli;
    logic [3:0]  w0_selj, w1_seli, w1_selj, b_sel, h_sel;
    logic [15:0] w0_data, w1_data, b_data, h_rdata, h_wdata;
    logic [2:0]  state_dbg;

    logic signed [15:0] W0 [4][16];
    logic signed [15:0] W1 [16][16];
    logic signed [15:0] B  [16];
    logic signed [15:0] H  [16];

    int n_checks = 0;
    int n_pass = 0;
    int wr_count = 0;
    logic [15:0] exp_q[$];

    rnn_step_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
        .busy(busy), .done(done),
        .w0_seli(w0_seli), .w0_selj(w0_selj), .w0_data(w0_data),
        .w1_seli(w1_seli), .w1_selj(w1_selj), .w1_data(w1_data),
        .b_sel(b_sel), .b_data(b_data),
        .h_sel(h_sel), .h_rdata(h_rdata),
        .h_write(h_write), .h_wdata(h_wdata),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Tensor memories: registered reads, hidden writes on the strobe.
    always @(posedge clk) begin
        w0_data <= W0[w0_seli][w0_selj];
        w1_data <= W1[w1_seli][w1_selj];
        b_data  <= B[b_sel];
        h_rdata <= H[h_sel];
        if (h_write) begin
            H[h_sel] = h_wdata;
            wr_count = wr_count + 1;
        end
    end

    // ---------------- reference model ----------------
    function automatic void model(input logic [63:0] x, input logic signed [15:0] hv [16]);
        for (int j = 0; j < 16; j++) begin
            longint s = 0;
            for (int i = 0; i < 4; i++)
                s += longint'($signed(x[16*i +: 16])) * longint'(W0[i][j]);
            for (int k = 0; k < 16; k++)
                s += longint'(hv[k]) * longint'(W1[k][j]);
            s += longint'(B[j]) * 256;
            s = s >>> 8;
            if (s > 32767) s = 32767;
            if (s < 0) s = 0;
            exp_q.push_back(16'(s));
        end
    endfunction

    function automatic logic signed [15:0] rnd_s(input int range);
        int v = int'($urandom_range(0, 2 * range - 1)) - range;
        return 16'(v);
    endfunction

    task automatic fill(input logic [15:0] w0v, input logic [15:0] w1v, input logic [15:0] bv);
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 4; i++) W0[i][j] = w0v;
            for (int k = 0; k < 16; k++) W1[k][j] = w1v;
            B[j] = bv;
        end
    endtask

    // ---------------- driver ----------------
    // Start is sampled in cycle 0; returns with the bench inside the done cycle.
    task automatic run_step(input logic [63:0] x, input bit noisy, output int done_cyc);
        x_in = x;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_cyc = -1;
        for (int c = 1; c <= 1000; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            if (noisy) begin
                x_in = {$urandom, $urandom};
                start = ($urandom_range(0, 3) == 0);
            end
            @(posedge clk); #1;
        end
        start = noisy && (done_cyc > 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [15:0] obs [10];
        string nm [10];
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        obs = '{16'(busy), 16'(done), 16'(h_write), 16'(w0_seli), 16'(w0_selj),
                16'(w1_seli), 16'(w1_selj), 16'(b_sel), 16'(h_sel), h_wdata};
        nm = '{"busy", "done", "h_write", "w0_seli", "w0_selj",
               "w1_seli", "w1_selj", "b_sel", "h_sel", "h_wdata"};
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (obs[i] !== 16'h0000) $display("FAIL reset_%s got %h want 0000", nm[i], obs[i]);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_bias();
        int dc;
        fill(16'h0000, 16'h0000, 16'h0100);
        for (int k = 0; k < 16; k++) H[k] = rnd_s(4096);
        model({$urandom, $urandom}, H);
        run_step({$urandom, $urandom}, 1'b0, dc);
        n_checks++;
        if (dc !== 369) $display("FAIL bias_done_cycle got %0d want 369", dc);
        else n_pass++;
        for (int j = 0; j < 16; j++) begin
            logic [15:0] e = exp_q.pop_front();
            n_checks++;
            if (H[j] !== e || e !== 16'h0100) $display("FAIL bias_h%0d got %h want %h", j, H[j], e);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int dc;
        logic [63:0] x;
        logic signed [15:0] old_h [16];
        logic [15:0] want;
        for (int sc = 0; sc < 4; sc++) begin
            case (sc)
                0: begin
                    fill(16'h0000, 16'h0000, 16'h0000);
                    for (int j = 0; j < 16; j++) W0[0][j] = 16'h0080;
                    for (int k = 0; k < 16; k++) H[k] = 16'h0000;
                    x = {48'h0, 16'h0100};
                end
                1: begin
                    fill(16'h0000, 16'h0000, 16'h0000);
                    for (int k = 0; k < 16; k++) begin
                        W1[k][k] = 16'h0100;
                        H[k] = 16'h0100 + 16'(k);
                    end
                    x = {$urandom, $urandom};
                end
                2: begin
                    fill(16'h7fff, 16'h0000, 16'h0000);
                    x = {4{16'h7fff}};
                end
                default: begin
                    fill(16'h0000, 16'h0000, 16'hff00);
                    for (int k = 0; k < 16; k++) H[k] = 16'h0100;
                    x = {$urandom, $urandom};
                end
            endcase
            old_h = H;
            model(x, H);
            run_step(x, 1'b0, dc);
            n_checks++;
            if (dc !== 369) $display("FAIL dir%0d_done_cycle got %0d want 369", sc, dc);
            else n_pass++;
            for (int j = 0; j < 16; j++) begin
                logic [15:0] e = exp_q.pop_front();
                case (sc)
                    0: want = 16'h0080;
                    1: want = old_h[j];
                    2: want = 16'h7fff;
                    default: want = 16'h0000;
                endcase
                n_checks++;
                if (H[j] !== e || e !== want) $display("FAIL dir%0d_h%0d got %h want %h", sc, j, H[j], want);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
    endtask

    // Random tensors, x scrambled and start poked while busy and in DONE.
    task automatic test_random();
        int dc;
        logic [63:0] x;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 16; j++) begin
                for (int i = 0; i < 4; i++) W0[i][j] = rnd_s(512);
                for (int k = 0; k < 16; k++) W1[k][j] = rnd_s(512);
                B[j] = rnd_s(256);
                H[j] = rnd_s(512);
            end
            for (int i = 0; i < 4; i++) x[16*i +: 16] = rnd_s(512);
            model(x, H);
            run_step(x, 1'b1, dc);
            n_checks++;
            if (dc !== 369) $display("FAIL rnd%0d_done_cycle got %0d want 369", r, dc);
            else n_pass++;
            for (int j = 0; j < 16; j++) begin
                logic [15:0] e = exp_q.pop_front();
                n_checks++;
                if (H[j] !== e) $display("FAIL rnd%0d_h%0d got %h want %h", r, j, H[j], e);
                else n_pass++;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n_checks++;
            if (busy !== 1'b0) $display("FAIL rnd%0d_idle_after_done got %b want 0", r, busy);
            else n_pass++;
            @(posedge clk); #1;
            n_checks++;
            if (busy !== 1'b0) $display("FAIL rnd%0d_done_start_ignored got %b want 0", r, busy);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int first_done = -1;
        int second_done = -1;
        int n_done_500 = 0;
        logic [63:0] x;
        logic signed [15:0] h1 [16];
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 4; i++) W0[i][j] = rnd_s(512);
            for (int k = 0; k < 16; k++) W1[k][j] = rnd_s(256);
            B[j] = rnd_s(256);
            H[j] = rnd_s(512);
        end
        for (int i = 0; i < 4; i++) x[16*i +: 16] = rnd_s(512);
        model(x, H);
        for (int j = 0; j < 16; j++) h1[j] = exp_q.pop_front();
        model(x, h1);
        x_in = x;
        start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 900; c++) begin
            if (done) begin
                if (c <= 500) n_done_500++;
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
            if (c == 370) begin
                n_checks++;
                if (busy !== 1'b0) $display("FAIL b2b_idle_c370 got %b want 0", busy);
                else n_pass++;
            end
            if (c == 371) begin
                n_checks++;
                if (busy !== 1'b1) $display("FAIL b2b_busy_c371 got %b want 1", busy);
                else n_pass++;
            end
            if (c == 500) start = 1'b0;
            if (second_done > 0) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_checks++;
        if (n_done_500 !== 1 || first_done !== 369)
            $display("FAIL b2b_first got %0d dones, first at %0d want 1 at 369", n_done_500, first_done);
        else n_pass++;
        n_checks++;
        if (second_done !== 739) $display("FAIL b2b_second_done got %0d want 739", second_done);
        else n_pass++;
        for (int j = 0; j < 16; j++) begin
            logic [15:0] e = exp_q.pop_front();
            n_checks++;
            if (H[j] !== e) $display("FAIL b2b_h%0d got %h want %h", j, H[j], e);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    // Abort at cycle abort_c; slots written before the abort must stick.
    task automatic test_reset_mid(input int abort_c);
        int dc;
        int wr0;
        int n_new = (abort_c > 353) ? abort_c - 353 : 0;
        logic [63:0] x;
        logic signed [15:0] old_h [16];
        logic [15:0] e_arr [16];
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 4; i++) W0[i][j] = rnd_s(512);
            for (int k = 0; k < 16; k++) W1[k][j] = rnd_s(512);
            B[j] = rnd_s(256);
            H[j] = rnd_s(512);
        end
        for (int i = 0; i < 4; i++) x[16*i +: 16] = rnd_s(512);
        old_h = H;
        model(x, H);
        for (int j = 0; j < 16; j++) e_arr[j] = exp_q.pop_front();
        wr0 = wr_count;
        x_in = x;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (abort_c - 1) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || h_write !== 1'b0)
            $display("FAIL rst%0d_immediate got busy=%b h_write=%b want 0 0", abort_c, busy, h_write);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (wr_count - wr0 !== n_new)
            $display("FAIL rst%0d_write_count got %0d want %0d", abort_c, wr_count - wr0, n_new);
        else n_pass++;
        for (int j = 0; j < 16; j++) begin
            logic [15:0] want = (j < n_new) ? e_arr[j] : old_h[j];
            n_checks++;
            if (H[j] !== want) $display("FAIL rst%0d_keep_h%0d got %h want %h", abort_c, j, H[j], want);
            else n_pass++;
        end
        // A fresh step after the abort runs to completion from the current h.
        model(x, H);
        run_step(x, 1'b0, dc);
        n_checks++;
        if (dc !== 369) $display("FAIL rst%0d_fresh_done got %0d want 369", abort_c, dc);
        else n_pass++;
        for (int j = 0; j < 16; j++) begin
            logic [15:0] e = exp_q.pop_front();
            n_checks++;
            if (H[j] !== e) $display("FAIL rst%0d_fresh_h%0d got %h want %h", abort_c, j, H[j], e);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        fill(16'h0000, 16'h0000, 16'h0000);
        for (int k = 0; k < 16; k++) H[k] = 16'h0000;
        test_reset();
        test_bias();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid(100);
        test_reset_mid(360);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
